// File: rtl/spi_rx_axil_fifo.sv
// spi_rx_axil_fifo: SPI receive deserialiser feeding a FIFO that software
// drains through a read-only AXI4-Lite slave (DATA / STATUS registers).
// Optional feature macro: SPI_RX_IRQ_EN adds the registered rx_irq output
// (rx_count >= IRQ_THRESH).
module spi_rx_axil_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LSB_FIRST  = 0,
  parameter int IRQ_THRESH = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [31:0]                   axi_lite_araddr,
  input  logic                          axi_lite_arvalid,
  output logic                          axi_lite_arready,
  output logic [31:0]                   axi_lite_rdata,
  output logic [1:0]                    axi_lite_rresp,
  output logic                          axi_lite_rvalid,
  input  logic                          axi_lite_rready,
  input  logic                          spi_clk_recv_int,
  input  logic                          spi_clk_en,
  input  logic                          spi_mosi,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count
`ifdef SPI_RX_IRQ_EN
  ,
  output logic                          rx_irq
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Receive path state
  logic [DATA_W-1:0] r_shift;
  logic [BCNT_W-1:0] r_bit_cnt;
  logic [DATA_W-1:0] w_shift_next;
  logic              w_strobe;
  logic              w_push;

  // FIFO state
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_en;
  logic              w_pop;
  logic              w_ovf_set;

  // Read channel state
  state_t            r_state;
  state_t            w_state_next;
  logic              w_ar_hs;
  logic              w_status_rd;
  logic [1:0]        w_addr_sel;
  logic [31:0]       w_resp_data;
  logic [1:0]        w_resp_code;
  logic [31:0]       r_rdata;
  logic [1:0]        r_rresp;
  logic              w_unused_addr;

  assign w_unused_addr = ^{axi_lite_araddr[31:4], axi_lite_araddr[1:0]};

  assign w_strobe  = spi_clk_recv_int & spi_clk_en;
  assign w_push    = w_strobe && (r_bit_cnt == LAST_BIT);
  assign w_full    = (r_count == DEPTH_CNT);
  assign w_empty   = (r_count == CNT_W'(0));
  // A full FIFO still accepts the word when the head is popped in the same cycle.
  assign w_wr_en   = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;

  assign w_addr_sel  = axi_lite_araddr[3:2];
  assign w_ar_hs     = (r_state == ST_IDLE) && axi_lite_arvalid;
  assign w_pop       = w_ar_hs && (w_addr_sel == 2'd0) && !w_empty;
  assign w_status_rd = w_ar_hs && (w_addr_sel == 2'd1);

  // Next shift-register value: new bit enters at the LSB (MSB-first) or MSB (LSB-first).
  always_comb begin
    w_shift_next = r_shift;
    if (LSB_FIRST == 0) begin
      w_shift_next = (r_shift << 1) | DATA_W'(spi_mosi);
    end else begin
      w_shift_next = (r_shift >> 1) | (DATA_W'(spi_mosi) << (DATA_W - 1));
    end
  end

  // Shift register and bit counter; an inactive frame discards any partial word.
  always_ff @(posedge clk) begin
    if (!resetn || !spi_clk_en) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_strobe) begin
      r_shift   <= w_shift_next;
      r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? BCNT_W'(0) : (r_bit_cnt + BCNT_W'(1));
    end else begin
      r_shift   <= r_shift;
      r_bit_cnt <= r_bit_cnt;
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= w_shift_next;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow wins over a simultaneous STATUS clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_status_rd) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  // Decode the read response for the presented address.
  always_comb begin
    w_resp_data = 32'h0000_0000;
    w_resp_code = RESP_SLVERR;
    case (w_addr_sel)
      2'd0: begin
        if (!w_empty) begin
          w_resp_data[DATA_W-1:0] = r_mem[r_rd_ptr];
          w_resp_code             = RESP_OKAY;
        end else begin
          w_resp_data = 32'h0000_0000;
          w_resp_code = RESP_SLVERR;
        end
      end
      2'd1: begin
        w_resp_data = {16'h0000, 8'(r_count), 5'b00000, r_ovf, w_full, w_empty};
        w_resp_code = RESP_OKAY;
      end
      default: begin
        w_resp_data = 32'h0000_0000;
        w_resp_code = RESP_SLVERR;
      end
    endcase
  end

  // Capture the response at the AR handshake and hold it through RESP.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rdata <= 32'h0000_0000;
      r_rresp <= 2'b00;
    end else if (w_ar_hs) begin
      r_rdata <= w_resp_data;
      r_rresp <= w_resp_code;
    end else begin
      r_rdata <= r_rdata;
      r_rresp <= r_rresp;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Read FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RESET: w_state_next = ST_IDLE;
      ST_IDLE:  w_state_next = axi_lite_arvalid ? ST_RESP : ST_IDLE;
      ST_RESP:  w_state_next = axi_lite_rready ? ST_IDLE : ST_RESP;
      default:  w_state_next = ST_RESET;
    endcase
  end

  // Read FSM outputs, decoded from the state register only.
  always_comb begin
    axi_lite_arready = 1'b0;
    axi_lite_rvalid  = 1'b0;
    case (r_state)
      ST_IDLE: axi_lite_arready = 1'b1;
      ST_RESP: axi_lite_rvalid  = 1'b1;
      default: begin
        axi_lite_arready = 1'b0;
        axi_lite_rvalid  = 1'b0;
      end
    endcase
  end

  assign axi_lite_rdata = r_rdata;
  assign axi_lite_rresp = r_rresp;
  assign rx_count       = r_count;

`ifdef SPI_RX_IRQ_EN
  logic r_irq;

  // Threshold interrupt, registered one cycle behind the occupancy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (r_count >= CNT_W'(IRQ_THRESH));
    end
  end

  assign rx_irq = r_irq;
`endif

endmodule

// File: doc/spi_rx_axil_fifo.md
# spi_rx_axil_fifo

Parametrised SPI receive engine that deserialises `spi_mosi` into DATA_W-bit words on qualified sample strobes. Completed words are buffered in a FIFO_DEPTH-entry FIFO. Software drains them over an AXI4-Lite read-only slave port that also exposes a status register. It is the next-generation receive path of the SPI master subsystem: it adds configurable width, depth, bit order, buffering, overflow detection and error responses.

## Interface
Parameters:
- DATA_W, 8, word width in bits; legal range 1..32.
- FIFO_DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- LSB_FIRST, 0, bit order: 0 means the first sampled bit is the word MSB, 1 means it is the LSB.
- IRQ_THRESH, 1, `rx_irq` asserts when `rx_count` >= this value (macro build only).

Ports (reset resetn, synchronous, active-low; clock clk):
- clk  in  1  system clock; all logic is on its rising edge.
- resetn  in  1  synchronous active-low reset.
- axi_lite_araddr  in  32  read address; only bits [3:2] are decoded.
- axi_lite_arvalid  in  1  read address valid.
- axi_lite_arready  out  1  read address ready.
- axi_lite_rdata  out  32  read data.
- axi_lite_rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- axi_lite_rvalid  out  1  read data valid.
- axi_lite_rready  in  1  read data ready.
- spi_clk_recv_int  in  1  single-cycle sample strobe from the SPI clock generator.
- spi_clk_en  in  1  frame active; high for the whole transfer.
- spi_mosi  in  1  serial data input.
- rx_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- rx_irq  out  1  threshold interrupt; this port exists only when SPI_RX_IRQ_EN is defined.

## Operation
Receive path:
- Bit counter range is 0..DATA_W-1. The shift register samples `spi_mosi` on each cycle where `spi_clk_recv_int` && `spi_clk_en`.
- With LSB_FIRST=0, data shifts in from the LSB (left shift). With LSB_FIRST=1, data shifts in from the MSB (right shift).
- On the DATA_W-th strobe, the assembled word is pushed into the FIFO and the bit counter returns to 0. Consecutive words in one frame are allowed.
- If `spi_clk_en` is low, the bit counter clears and any partial word is discarded (frame abort).
- If a push occurs while the FIFO is full with no pop in the same cycle, the word is dropped and the sticky `ovf` flag is set.
- If push and pop occur in the same cycle while full, both succeed.

Read FSM, states IDLE and RESP:
- IDLE: `axi_lite_arready`=1. When `arvalid` is high, the AR handshake completes, the response is computed and registered, and the FSM moves to RESP.
- RESP: `axi_lite_rvalid`=1 and `rdata`/`rresp` are held stable until `rready`; the FSM then returns to IDLE. `arready`=0 while in RESP.

Register map, indexed by araddr[3:2]:
- 0 DATA: when the FIFO is not empty, the head word (zero-extended) is popped at the AR handshake and the response is OKAY. When the FIFO is empty, rdata=0, rresp=SLVERR, and nothing is popped.
- 1 STATUS: rdata = {16'b0, 8'(rx_count), 5'b0, ovf, full, empty}, OKAY. Reading STATUS clears `ovf` in the handshake cycle. If an overflow occurs in that same cycle, `ovf` stays set.
- 2, 3: rdata=0, rresp=SLVERR.

## Timing
- Reset values: `arready`=0, `rvalid`=0, `rdata`=0, `rresp`=0, `rx_count`=0, `rx_irq`=0. The FIFO, pointers, bit counter and `ovf` all clear.
- After reset release, `arready` rises one cycle later (the FSM spends one cycle in a RESET state, then enters IDLE).
- The completing strobe edge registers the FIFO write. `rx_count` reflects the push one cycle after that strobe.
- `rvalid` asserts the cycle after the AR handshake. The minimum read is 2 cycles (AR handshake, then R handshake); back-to-back reads take 2 cycles each.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. Full and empty are derived from `rx_count`.
- Reset asserted mid-word or mid-RESP aborts everything immediately; no handshake completes.

## Configuration
- SPI_RX_IRQ_EN defined: the `rx_irq` port and a registered comparison are compiled in. `rx_irq` = (`rx_count` >= IRQ_THRESH), updated one cycle after the count changes.
- SPI_RX_IRQ_EN undefined: the port and logic are absent; IRQ_THRESH is ignored.

## Test plan
- DATA_W=8, LSB_FIRST=0: shift in 8'hA5 MSB-first, then read addr 0x0 -> rdata=32'h000000A5, OKAY; `rx_count` goes 1 then 0.
- LSB_FIRST=1, DATA_W=12: send bits of 12'h3C1 LSB-first, then read -> rdata=32'h000003C1.
- Send 5 words with FIFO_DEPTH=4 and no reads -> STATUS = 0x00000406 (count 4, ovf, full). A second STATUS read -> 0x00000402. The DATA reads return the first 4 words in order.
- Read DATA with the FIFO empty -> rdata=0, rresp=2'b10, `rx_count` stays 0. Read addr 0xC -> SLVERR.
- Drop `spi_clk_en` after 3 bits, then send a full 8'h5A -> a single entry, 8'h5A.
- Hold `rready` low for 5 cycles in RESP -> `rvalid` and `rdata` are held stable and `arready`=0. With SPI_RX_IRQ_EN and IRQ_THRESH=2: push 2 words -> `rx_irq`=1; pop one -> `rx_irq`=0.
